// File: rtl/zmodem_pkg.sv
// Widths and types shared by the symbol serializer and deserializer.
package zmodem_pkg;

  localparam int BLOCK_W        = 128;
  localparam int SYM_W          = 2;
  localparam int SYMS_PER_BLOCK = BLOCK_W / SYM_W;
  localparam int CNT_W          = $clog2(SYMS_PER_BLOCK);

  typedef logic [BLOCK_W-1:0] cipher_block_t;
  typedef logic [SYM_W-1:0]   symbol_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/symbol_serializer.sv
// Splits 128-bit cipher blocks into 2-bit symbols, MSB pair first, with one
// holding slot so consecutive blocks stream without an idle symbol slot.
module symbol_serializer
  import zmodem_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [BLOCK_W-1:0] enc_block,
  input  logic               enc_valid,
  output logic               enc_ready,
  output logic [SYM_W-1:0]   symbol_out,
  output logic               symbol_valid,
  input  logic               symbol_ready,
  output logic               symbol_first,
  output logic               symbol_last,
  output logic               state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // A producer holds valid and data stable until that edge; ready may
  // depend on state but never on the same-cycle valid.

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYMS_PER_BLOCK - 1);

  ser_state_e    state;
  cipher_block_t shift_reg;
  cipher_block_t hold_reg;
  logic          hold_full;
  logic [CNT_W-1:0] sym_cnt;

  logic accept;
  logic sym_hs;

  assign enc_ready    = !hold_full && !reset;
  assign accept       = enc_valid && enc_ready;
  assign symbol_valid = (state == SHIFT);
  assign sym_hs       = symbol_valid && symbol_ready;
  assign symbol_out   = shift_reg[BLOCK_W-1 -: SYM_W];
  assign symbol_first = symbol_valid && (sym_cnt == '0);
  assign symbol_last  = symbol_valid && (sym_cnt == LAST_CNT);
  assign state_dbg    = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      sym_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= enc_block;
            sym_cnt   <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (sym_hs && (sym_cnt != LAST_CNT)) begin
            shift_reg <= shift_reg << SYM_W;
            sym_cnt   <= sym_cnt + 1'b1;
            if (accept) begin
              hold_reg  <= enc_block;
              hold_full <= 1'b1;
            end
          end else if (sym_hs) begin
            // End of block: the held block wins over a fresh one; enc_ready
            // is low whenever hold_full is set, so both cannot be pending.
            sym_cnt <= '0;
            if (hold_full) begin
              shift_reg <= hold_reg;
              hold_full <= 1'b0;
            end else if (accept) begin
              shift_reg <= enc_block;
            end else begin
              // Final shift leaves the register all-zero while idle.
              shift_reg <= shift_reg << SYM_W;
              state     <= IDLE;
            end
          end else if (accept) begin
            hold_reg  <= enc_block;
            hold_full <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
